// File: rtl/mem_arbiter_if.sv
// Request/fill signals of both caches plus the main-memory port of mem_arbiter.
// master is the arbiter's view; slave is the view of the caches and memory around it.
interface mem_arbiter_if #(
   parameter int ADDRESS_WIDTH    = 32,
   parameter int CACHE_LINE_WIDTH = 128
);
   logic                        ic_req_in;
   logic                        ic_req_write_in;
   logic [ADDRESS_WIDTH-1:0]    ic_req_addr_in;
   logic [CACHE_LINE_WIDTH-1:0] ic_req_data_in;
   logic                        ic_grant_out;
   logic                        ic_fill_out;
   logic                        dc_req_in;
   logic                        dc_req_write_in;
   logic [ADDRESS_WIDTH-1:0]    dc_req_addr_in;
   logic [CACHE_LINE_WIDTH-1:0] dc_req_data_in;
   logic                        dc_grant_out;
   logic                        dc_fill_out;
   logic [CACHE_LINE_WIDTH-1:0] fill_data_out;
   logic [ADDRESS_WIDTH-1:0]    fill_addr_out;
   logic                        mem_req_out;
   logic                        mem_req_write_out;
   logic [ADDRESS_WIDTH-1:0]    mem_req_addr_out;
   logic [CACHE_LINE_WIDTH-1:0] mem_req_data_out;
   logic                        mem_ready_in;
   logic                        mem_resp_in;
   logic [CACHE_LINE_WIDTH-1:0] mem_resp_data_in;
   logic                        busy_out;

   modport master (
      input  ic_req_in, ic_req_write_in, ic_req_addr_in, ic_req_data_in,
             dc_req_in, dc_req_write_in, dc_req_addr_in, dc_req_data_in,
             mem_ready_in, mem_resp_in, mem_resp_data_in,
      output ic_grant_out, ic_fill_out, dc_grant_out, dc_fill_out,
             fill_data_out, fill_addr_out,
             mem_req_out, mem_req_write_out, mem_req_addr_out, mem_req_data_out,
             busy_out
   );

   modport slave (
      output ic_req_in, ic_req_write_in, ic_req_addr_in, ic_req_data_in,
             dc_req_in, dc_req_write_in, dc_req_addr_in, dc_req_data_in,
             mem_ready_in, mem_resp_in, mem_resp_data_in,
      input  ic_grant_out, ic_fill_out, dc_grant_out, dc_fill_out,
             fill_data_out, fill_addr_out,
             mem_req_out, mem_req_write_out, mem_req_addr_out, mem_req_data_out,
             busy_out
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache and dcache: dcache has priority,
// but after STARVE_LIMIT consecutive dcache wins a waiting icache is served.
module mem_arbiter #(
   parameter int ADDRESS_WIDTH    = 32,
   parameter int CACHE_LINE_WIDTH = 128,
   parameter int STARVE_LIMIT     = 4
) (
   input logic           clk,
   input logic           reset,
   mem_arbiter_if.master bus
);
   localparam int STREAK_WIDTH = $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                      state, state_next;
   logic                        owner_dc, owner_dc_next;
   logic                        lat_write, lat_write_next;
   logic [ADDRESS_WIDTH-1:0]    lat_addr, lat_addr_next;
   logic [CACHE_LINE_WIDTH-1:0] lat_data, lat_data_next;
   logic [STREAK_WIDTH-1:0]     dc_streak, dc_streak_next;
   logic [CACHE_LINE_WIDTH-1:0] fill_data, fill_data_next;
   logic [ADDRESS_WIDTH-1:0]    fill_addr, fill_addr_next;
   logic                        ic_wins;
   logic                        in_issue;
   logic                        in_flight;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner_dc  <= 1'b0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_data  <= '0;
         dc_streak <= '0;
         fill_data <= '0;
         fill_addr <= '0;
      end else begin
         state     <= state_next;
         owner_dc  <= owner_dc_next;
         lat_write <= lat_write_next;
         lat_addr  <= lat_addr_next;
         lat_data  <= lat_data_next;
         dc_streak <= dc_streak_next;
         fill_data <= fill_data_next;
         fill_addr <= fill_addr_next;
      end
   end

   always_comb begin
      state_next     = state;
      owner_dc_next  = owner_dc;
      lat_write_next = lat_write;
      lat_addr_next  = lat_addr;
      lat_data_next  = lat_data;
      dc_streak_next = dc_streak;
      fill_data_next = fill_data;
      fill_addr_next = fill_addr;
      ic_wins        = bus.ic_req_in && (!bus.dc_req_in || dc_streak == STREAK_MAX);
      case (state)
         IDLE: begin
            if (bus.ic_req_in || bus.dc_req_in) begin
               state_next    = ISSUE;
               owner_dc_next = !ic_wins;
               if (ic_wins) begin
                  lat_write_next = bus.ic_req_write_in;
                  lat_addr_next  = bus.ic_req_addr_in;
                  lat_data_next  = bus.ic_req_data_in;
                  dc_streak_next = '0;
               end else begin
                  lat_write_next = bus.dc_req_write_in;
                  lat_addr_next  = bus.dc_req_addr_in;
                  lat_data_next  = bus.dc_req_data_in;
                  // The streak only measures how long a waiting icache has been passed over
                  if (!bus.ic_req_in) begin
                     dc_streak_next = '0;
                  end else if (dc_streak != STREAK_MAX) begin
                     dc_streak_next = dc_streak + STREAK_WIDTH'(1);
                  end
               end
            end
         end
         ISSUE: begin
            if (bus.mem_ready_in) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (bus.mem_resp_in) begin
               state_next = RESP;
               if (!lat_write) begin
                  fill_data_next = bus.mem_resp_data_in;
                  fill_addr_next = lat_addr;
               end
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_issue  = (state == ISSUE);
   assign in_flight = (state != IDLE);

   assign bus.busy_out          = in_flight;
   assign bus.ic_grant_out      = in_flight && !owner_dc;
   assign bus.dc_grant_out      = in_flight && owner_dc;
   assign bus.ic_fill_out       = (state == RESP) && !lat_write && !owner_dc;
   assign bus.dc_fill_out       = (state == RESP) && !lat_write && owner_dc;
   assign bus.fill_data_out     = fill_data;
   assign bus.fill_addr_out     = fill_addr;
   assign bus.mem_req_out       = in_issue;
   assign bus.mem_req_write_out = in_issue && lat_write;
   assign bus.mem_req_addr_out  = in_issue ? lat_addr : '0;
   assign bus.mem_req_data_out  = in_issue ? lat_data : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a request-level arbitration/memory model feeds
// expected transactions to a queue that an independent monitor checks against the DUT.
module tb_mem_arbiter;
   localparam int AW    = 32;
   localparam int LW    = 128;
   localparam int LIMIT = 4;

   typedef struct {
      bit            dc;
      bit            write;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
      logic [LW-1:0] fill_data;
      logic [AW-1:0] fill_addr;
   } txn_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   int            checks = 0;
   int            errors = 0;
   txn_t          exp_q[$];
   byte           grant_log[$];
   logic [LW-1:0] ref_mem [logic [AW-1:0]];
   logic [LW-1:0] bfm_mem [logic [AW-1:0]];
   int            ref_streak = 0;
   logic [LW-1:0] ref_fill_data = '0;
   logic [AW-1:0] ref_fill_addr = '0;
   bit            mon_en = 1'b1;
   bit            fixed_timing = 1'b0;
   bit            resp_enable = 1'b1;
   int            ready_delay = -1;
   logic          ready_drv = 1'b0;
   logic          resp_drv = 1'b0;
   logic          spurious = 1'b0;
   logic [LW-1:0] resp_data = '0;
   string         exp_order = "DDDDIDDDDI";

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(LW)) bus ();

   assign bus.mem_ready_in     = ready_drv;
   assign bus.mem_resp_in      = resp_drv | spurious;
   assign bus.mem_resp_data_in = resp_data;

   mem_arbiter #(
      .ADDRESS_WIDTH(AW),
      .CACHE_LINE_WIDTH(LW),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   function automatic logic [LW-1:0] default_line(input logic [AW-1:0] a);
      return {4{a ^ 32'hC0DE_0000}};
   endfunction

   task automatic finish_sim();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic checkOutput(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      checkOutput({tag, "_flags"}, {bus.ic_grant_out, bus.ic_fill_out, bus.dc_grant_out, bus.dc_fill_out,
                                    bus.mem_req_out, bus.mem_req_write_out, bus.busy_out}, '0);
      checkOutput({tag, "_mem_addr"}, bus.mem_req_addr_out, '0);
      checkOutput({tag, "_mem_data"}, bus.mem_req_data_out, '0);
      checkOutput({tag, "_fill_data"}, bus.fill_data_out, '0);
      checkOutput({tag, "_fill_addr"}, bus.fill_addr_out, '0);
   endtask

   task automatic set_req(input bit dc, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
      if (dc) begin
         bus.dc_req_in = 1'b1; bus.dc_req_write_in = wr; bus.dc_req_addr_in = a; bus.dc_req_data_in = d;
      end else begin
         bus.ic_req_in = 1'b1; bus.ic_req_write_in = wr; bus.ic_req_addr_in = a; bus.ic_req_data_in = d;
      end
   endtask

   task automatic random_req(input bit dc);
      set_req(dc, 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 7)) * 32'h40,
              {$urandom, $urandom, $urandom, $urandom});
   endtask

   // One arbitration round: decide the winner from the request flags, predict the
   // outcome, then hold the loser's request while the winner's transaction runs.
   task automatic applyStimulus();
      txn_t t;
      bit   icw;
      int   n;
      icw = bus.ic_req_in && (!bus.dc_req_in || ref_streak == LIMIT);
      if (icw) ref_streak = 0;
      else if (bus.ic_req_in) ref_streak = (ref_streak < LIMIT) ? ref_streak + 1 : LIMIT;
      else ref_streak = 0;
      t.dc    = !icw;
      t.write = icw ? bus.ic_req_write_in : bus.dc_req_write_in;
      t.addr  = icw ? bus.ic_req_addr_in : bus.dc_req_addr_in;
      t.data  = icw ? bus.ic_req_data_in : bus.dc_req_data_in;
      if (t.write) begin
         ref_mem[t.addr] = t.data;
      end else begin
         ref_fill_data = ref_mem.exists(t.addr) ? ref_mem[t.addr] : default_line(t.addr);
         ref_fill_addr = t.addr;
      end
      t.fill_data = ref_fill_data;
      t.fill_addr = ref_fill_addr;
      exp_q.push_back(t);
      @(negedge clk);
      if (bus.busy_out !== 1'b1) begin
         checks++; errors++;
         $display("[TB] FAIL start_timeout: busy_out=%b, required 1", bus.busy_out);
         finish_sim();
      end
      if (t.dc) bus.dc_req_in = 1'b0;
      else bus.ic_req_in = 1'b0;
      n = 0;
      while (bus.busy_out !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy_out !== 1'b0) begin
         checks++; errors++;
         $display("[TB] FAIL done_timeout: busy_out=%b after 100 cycles, required 0", bus.busy_out);
         finish_sim();
      end
   endtask

   initial begin : responder
      int            d;
      logic          w;
      logic [AW-1:0] a;
      logic [LW-1:0] wd;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && bus.mem_req_out === 1'b1) begin
            if (ready_delay >= 0) d = ready_delay;
            else if (fixed_timing) d = 0;
            else d = int'($urandom_range(0, 10));
            repeat (d) @(negedge clk);
            w  = bus.mem_req_write_out;
            a  = bus.mem_req_addr_out;
            wd = bus.mem_req_data_out;
            ready_drv = 1'b1;
            @(negedge clk);
            ready_drv = 1'b0;
            d = fixed_timing ? 2 : int'($urandom_range(0, 4));
            repeat (d) @(negedge clk);
            if (resp_enable) begin
               if (w) begin
                  bfm_mem[a] = wd;
                  resp_data = {$urandom, $urandom, $urandom, $urandom};
               end else begin
                  resp_data = bfm_mem.exists(a) ? bfm_mem[a] : default_line(a);
               end
               resp_drv = 1'b1;
               @(negedge clk);
               resp_drv = 1'b0;
            end
         end
      end
   end

   initial begin : monitor
      txn_t cur;
      bit   active;
      int   fills;
      int   gcycles;
      active = 1'b0; fills = 0; gcycles = 0;
      forever begin
         @(negedge clk);
         if (!mon_en || reset !== 1'b1) begin
            active = 1'b0;
            continue;
         end
         checkOutput("grant_exclusive", bus.ic_grant_out & bus.dc_grant_out, '0);
         if (!active && bus.busy_out) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL unexpected_txn: busy_out=1 with nothing issued, required 0");
            end else begin
               cur = exp_q.pop_front();
               active = 1'b1; fills = 0; gcycles = 0;
               grant_log.push_back(bus.dc_grant_out ? 8'h44 : 8'h49);
               checkOutput("grant_owner", {bus.ic_grant_out, bus.dc_grant_out}, cur.dc ? 2'b01 : 2'b10);
            end
         end
         if (active && bus.busy_out) begin
            if (cur.dc ? bus.dc_grant_out : bus.ic_grant_out) gcycles++;
            if (bus.mem_req_out) begin
               checkOutput("mem_write", bus.mem_req_write_out, cur.write);
               checkOutput("mem_addr", bus.mem_req_addr_out, cur.addr);
               if (cur.write) checkOutput("mem_data", bus.mem_req_data_out, cur.data);
            end
            if (bus.ic_fill_out || bus.dc_fill_out) begin
               fills++;
               checkOutput("fill_owner", {bus.ic_fill_out, bus.dc_fill_out}, cur.dc ? 2'b01 : 2'b10);
               checkOutput("fill_data", bus.fill_data_out, cur.fill_data);
               checkOutput("fill_addr", bus.fill_addr_out, cur.fill_addr);
            end
         end else if (active) begin
            checkOutput("fill_count", fills, cur.write ? 0 : 1);
            checkOutput("fill_data_hold", bus.fill_data_out, cur.fill_data);
            checkOutput("fill_addr_hold", bus.fill_addr_out, cur.fill_addr);
            if (fixed_timing) checkOutput("grant_cycles", gcycles, 5);
            active = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      checks++; errors++;
      $display("[TB] FAIL watchdog: time limit reached, required completion");
      finish_sim();
   end

   initial begin : main
      bus.ic_req_in = 1'b0; bus.ic_req_write_in = 1'b0; bus.ic_req_addr_in = '0; bus.ic_req_data_in = '0;
      bus.dc_req_in = 1'b0; bus.dc_req_write_in = 1'b0; bus.dc_req_addr_in = '0; bus.dc_req_data_in = '0;
      ref_mem[32'h100] = {16{8'hAA}};
      bfm_mem[32'h100] = {16{8'hAA}};
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      reset = 1'b1;
      @(negedge clk);
      check_idle_zero("post_reset");

      $display("[TB] single icache read");
      fixed_timing = 1'b1;
      set_req(1'b0, 1'b0, 32'h100, '0);
      applyStimulus();
      checkOutput("ic_read_fill_data", bus.fill_data_out, {16{8'hAA}});
      checkOutput("ic_read_fill_addr", bus.fill_addr_out, 32'h100);

      $display("[TB] dcache write");
      set_req(1'b1, 1'b1, 32'h200, {16{8'h55}});
      applyStimulus();
      checkOutput("dc_write_mem", bfm_mem.exists(32'h200) ? bfm_mem[32'h200] : '0, {16{8'h55}});
      checkOutput("dc_write_fill_hold", bus.fill_data_out, {16{8'hAA}});

      $display("[TB] simultaneous requests");
      grant_log.delete();
      set_req(1'b0, 1'b0, 32'h140, '0);
      set_req(1'b1, 1'b0, 32'h180, '0);
      applyStimulus();
      applyStimulus();
      checkOutput("both_first", grant_log.size() > 0 ? grant_log[0] : 8'h3F, 8'h44);
      checkOutput("both_second", grant_log.size() > 1 ? grant_log[1] : 8'h3F, 8'h49);

      $display("[TB] starvation guard");
      fixed_timing = 1'b0;
      grant_log.delete();
      random_req(1'b0);
      random_req(1'b1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
         if (i < 9) begin
            if (!bus.dc_req_in) random_req(1'b1);
            if (!bus.ic_req_in) random_req(1'b0);
         end
      end
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("grant_order_%0d", i), grant_log.size() > i ? grant_log[i] : 8'h3F, exp_order[i]);
      end

      $display("[TB] memory stall");
      ready_delay = 10;
      applyStimulus();
      ready_delay = -1;

      $display("[TB] random traffic");
      for (int r = 0; r < 40; r++) begin
         if (!bus.ic_req_in && $urandom_range(0, 9) < 6) random_req(1'b0);
         if (!bus.dc_req_in && $urandom_range(0, 9) < 6) random_req(1'b1);
         if (!bus.ic_req_in && !bus.dc_req_in) random_req(1'($urandom_range(0, 1)));
         applyStimulus();
      end
      bus.ic_req_in = 1'b0;
      bus.dc_req_in = 1'b0;

      $display("[TB] reset during WAIT");
      mon_en = 1'b0;
      fixed_timing = 1'b1;
      resp_enable = 1'b0;
      @(negedge clk);
      set_req(1'b1, 1'b0, 32'h300, '0);
      repeat (3) @(negedge clk);
      bus.dc_req_in = 1'b0;
      reset = 1'b0;
      #1;
      check_idle_zero("wait_reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      spurious = 1'b1;
      @(negedge clk);
      spurious = 1'b0;
      check_idle_zero("spurious_resp");
      @(negedge clk);
      check_idle_zero("spurious_resp_after");
      ref_streak = 0;
      ref_fill_data = '0;
      ref_fill_addr = '0;
      resp_enable = 1'b1;
      fixed_timing = 1'b0;
      mon_en = 1'b1;

      $display("[TB] random traffic after reset");
      for (int r = 0; r < 10; r++) begin
         if (!bus.ic_req_in && $urandom_range(0, 9) < 6) random_req(1'b0);
         if (!bus.dc_req_in && $urandom_range(0, 9) < 6) random_req(1'b1);
         if (!bus.ic_req_in && !bus.dc_req_in) random_req(1'($urandom_range(0, 1)));
         applyStimulus();
      end
      bus.ic_req_in = 1'b0;
      bus.dc_req_in = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("queue_empty", exp_q.size(), '0);
      checkOutput("final_idle", bus.busy_out, 1'b0);
      finish_sim();
   end
endmodule
